// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low one-hot anode select for the given digit slot.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 decode to a dash so corrupted counter values are visible.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with leading-zero blanking.
// Optional display blinking is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_dp,
  input  logic        lz_blank,
`ifdef SEG7_BLINK_EN
  input  logic        blink,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]      cnt_reg;
  logic [1:0]            idx_reg;
  logic                  tick;
  logic [6:0]            seg_dec [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_chain;
  logic                  dark;
  logic                  digit_blank;
  logic [3:0]            an_reg, an_next;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;

  assign tick = (cnt_reg == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick)
        idx_reg <= idx_reg + 2'd1;
    end
  end

  // lz_chain[k]: digit k and every higher digit are zero; digit 0 never blanks.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_to_seg7 u_dec (
        .bcd (i_data[gi*4 +: 4]),
        .seg (seg_dec[gi])
      );
      if (gi == 0) begin : g_lsd
        assign lz_chain[gi] = 1'b0;
      end else if (gi == NUM_DIGITS - 1) begin : g_msd
        assign lz_chain[gi] = (i_data[gi*4 +: 4] == 4'd0);
      end else begin : g_mid
        assign lz_chain[gi] = (i_data[gi*4 +: 4] == 4'd0) & lz_chain[gi+1];
      end
    end
  endgenerate

`ifdef SEG7_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] bcnt_reg;
  logic               phase_reg;

  // The phase keeps running even while blink is low so re-enabling is in step.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (tick) begin
      if (bcnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
        bcnt_reg  <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        bcnt_reg <= bcnt_reg + 1'b1;
      end
    end
  end

  assign dark = blink & phase_reg;
`else
  assign dark = 1'b0;
`endif

  assign digit_blank = lz_blank & lz_chain[idx_reg];

  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (!dark && !digit_blank) begin
      an_next  = anode_for(idx_reg);
      seg_next = seg_dec[idx_reg];
      dp_next  = ~i_dp[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an_reg  <= 4'b1111;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle model pushes the expected
// {an,seg,dp} each clock and every task pops and compares after the edge.
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic [3:0]  i_dp = 4'b0000;
  logic        lz_blank = 1'b0;
  logic        blink_tb = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_mis = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got, expv;

  int         m_cnt = 0;
  logic [1:0] m_idx = 2'd0;
  int         m_bcnt = 0;
  logic       m_phase = 1'b0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .i_data   (i_data),
    .i_dp     (i_dp),
    .lz_blank (lz_blank),
`ifdef SEG7_BLINK_EN
    .blink    (blink_tb),
`endif
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  function automatic logic [11:0] model_out(input logic [1:0] idx, input logic [15:0] d,
                                            input logic [3:0] p, input logic lz,
                                            input logic dark);
    logic [3:0] dig;
    logic       blank;
    logic [6:0] s;
    dig   = d[idx*4 +: 4];
    blank = 1'b0;
    if (lz && idx != 2'd0) begin
      blank = 1'b1;
      for (int k = int'(idx); k < 4; k++)
        if (d[k*4 +: 4] != 4'd0) blank = 1'b0;
    end
    s = (dig < 4'd10) ? pat[dig] : 7'b0111111;
    if (blank || dark) return {4'b1111, 7'b1111111, 1'b1};
    return {~(4'b0001 << idx), s, ~p[idx]};
  endfunction

  task automatic model_zero();
    m_cnt = 0; m_idx = 2'd0; m_bcnt = 0; m_phase = 1'b0;
  endtask

  // Push the expectation for the coming edge, clock it, advance the model.
  task automatic step();
    logic dark_now;
`ifdef SEG7_BLINK_EN
    dark_now = blink_tb & m_phase;
`else
    dark_now = 1'b0;
`endif
    if (!clr_n) exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
    else        exp_q.push_back(model_out(m_idx, i_data, i_dp, lz_blank, dark_now));
    @(posedge clk);
    if (!clr_n) model_zero();
    else if (m_cnt == RD - 1) begin
      m_cnt = 0;
      m_idx = m_idx + 2'd1;
      if (m_bcnt == BD - 1) begin m_bcnt = 0; m_phase = ~m_phase; end
      else m_bcnt++;
    end else m_cnt++;
    #1;
  endtask

  // Assumes the bench sits just after a rising edge.
  task automatic reset_and_release();
    #2 clr_n = 1'b0;
    model_zero();
    #5 clr_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
    got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
    if (got !== expv) begin n_mis++; $display("FAIL reset_hold got=%h exp=%h", got, expv); end
    else $display("reset_hold ok an=%b seg=%b dp=%b", an, seg, dp);
    #1 clr_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL reset_release c=%0d got=%h exp=%h", c, got, expv); end
      else $display("reset_release c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
  endtask

  task automatic test_scan();
    reset_and_release();
    i_data = 16'h1234; lz_blank = 1'b0; i_dp = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL scan c=%0d got=%h exp=%h", c, got, expv); end
      else $display("scan c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
  endtask

  task automatic test_lz_blank();
    reset_and_release();
    i_data = 16'h0050; lz_blank = 1'b1; i_dp = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL lz_blank c=%0d got=%h exp=%h", c, got, expv); end
      else $display("lz_blank c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
  endtask

  task automatic test_dash();
    reset_and_release();
    i_data = 16'h000A; i_dp = 4'b0000;
    for (int c = 0; c < 32; c++) begin
      lz_blank = (c >= 16);
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL dash c=%0d got=%h exp=%h", c, got, expv); end
      else $display("dash c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
    i_data = 16'h0A00; lz_blank = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL dash_chain c=%0d got=%h exp=%h", c, got, expv); end
      else $display("dash_chain c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
  endtask

  task automatic test_dp();
    reset_and_release();
    i_data = 16'h1234; lz_blank = 1'b0; i_dp = 4'b0100;
    for (int c = 0; c < 32; c++) begin
      if (c == 16) begin i_data = 16'h0034; lz_blank = 1'b1; end
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL dp c=%0d got=%h exp=%h", c, got, expv); end
      else $display("dp c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
  endtask

  task automatic test_midslot_change();
    reset_and_release();
    for (int c = 0; c < 40; c++) begin
      i_data   = 16'($urandom);
      if (c % 3 == 0) i_data[15:8] = 8'h00;
      i_dp     = 4'($urandom);
      lz_blank = 1'($urandom);
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL midslot c=%0d data=%h got=%h exp=%h", c, i_data, got, expv); end
      else $display("midslot c=%0d ok data=%h an=%b seg=%b dp=%b", c, i_data, an, seg, dp);
    end
  endtask

  task automatic test_reset_mid();
    reset_and_release();
    i_data = 16'h5678; lz_blank = 1'b0; i_dp = 4'b1111;
    for (int c = 0; c < 20 && !(m_idx == 2'd2 && m_cnt == 1); c++) begin
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, got, expv); end
      else $display("pre_reset c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
    n_cmp++;
    if (m_idx !== 2'd2) begin n_mis++; $display("FAIL reach_idx2 got=%0d exp=2", m_idx); end
    #2 clr_n = 1'b0;
    model_zero();
    #1;
    exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
    got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
    if (got !== expv) begin n_mis++; $display("FAIL async_clear got=%h exp=%h", got, expv); end
    else $display("async_clear ok an=%b seg=%b dp=%b", an, seg, dp);
    step();
    got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
    if (got !== expv) begin n_mis++; $display("FAIL clear_held got=%h exp=%h", got, expv); end
    else $display("clear_held ok an=%b seg=%b dp=%b", an, seg, dp);
    #3 clr_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, got, expv); end
      else $display("post_reset c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink();
    int dark_cnt;
    reset_and_release();
    i_data = 16'h8888; lz_blank = 1'b0; i_dp = 4'b0000; blink_tb = 1'b1;
    dark_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      if (an == 4'b1111) dark_cnt++;
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL blink_on c=%0d got=%h exp=%h", c, got, expv); end
      else $display("blink_on c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
    n_cmp++;
    if (dark_cnt !== 16) begin n_mis++; $display("FAIL blink_dark_count got=%0d exp=16", dark_cnt); end
    blink_tb = 1'b0;
    dark_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (an == 4'b1111) dark_cnt++;
      got = {an, seg, dp}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin n_mis++; $display("FAIL blink_off c=%0d got=%h exp=%h", c, got, expv); end
      else $display("blink_off c=%0d ok an=%b seg=%b dp=%b", c, an, seg, dp);
    end
    n_cmp++;
    if (dark_cnt !== 0) begin n_mis++; $display("FAIL blink_off_dark_count got=%0d exp=0", dark_cnt); end
  endtask
`endif

  initial begin
    #12;
    test_reset();
    test_scan();
    test_lz_blank();
    test_dash();
    test_dp();
    test_midslot_change();
    test_reset_mid();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
